// File: rtl/text_edit_ctrl.sv
// Text-mode editor controller: maps the VGA scan position onto a character RAM,
// overlays a blinking cursor, and applies keyboard edits to the RAM during blanking.
//
// state | meaning
// IDLE  | waiting for a key; key_ready=1
// WRITE | one pending character write, issued on the first blanking cycle
// CLEAR | filling every cell with 0x20 in ascending order, blanking cycles only
module text_edit_ctrl #(
    parameter int COLS         = 70,
    parameter int ROWS         = 30,
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [7:0]  key_ascii,
    output logic        key_ready,
    input  logic [9:0]  h_addr,
    input  logic [9:0]  v_addr,
    input  logic        valid,
    output logic [11:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  char_code,
    output logic [3:0]  pix_x,
    output logic [3:0]  pix_y,
    output logic        cursor_on
);

    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [11:0]        LAST_CELL  = 12'(ROWS * COLS - 1);
    localparam logic [9:0]         H_LIMIT    = 10'(9 * COLS);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [11:0]        wr_addr_q, wr_addr_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic               wr_adv_q, wr_adv_d;
    logic [11:0]        clr_ptr_q, clr_ptr_d;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_q;
    logic               disp_ok_q;
    logic [3:0]         pix_x_q, pix_y_q;
    logic               cursor_on_q;

    // ---------------- display path ----------------
    logic [11:0] disp_col, disp_row, disp_addr;
    logic        disp_in, cursor_hit;

    assign disp_col   = 12'(h_addr / 10'd9);
    assign disp_row   = 12'(v_addr[9:4]);
    assign disp_addr  = disp_row * 12'(COLS) + disp_col;
    assign disp_in    = valid && (h_addr < H_LIMIT) && (disp_row < 12'(ROWS));
    assign cursor_hit = (disp_row == 12'(row_q)) && (disp_col == 12'(col_q));

    // The RAM's own output register supplies the pipeline stage for the glyph;
    // only the in-range qualifier travels alongside it here.
    assign char_code = disp_ok_q ? mem_rdata : 8'h00;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign cursor_on = cursor_on_q;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            disp_ok_q   <= 1'b0;
            pix_x_q     <= 4'd0;
            pix_y_q     <= 4'd0;
            cursor_on_q <= 1'b0;
        end else begin
            disp_ok_q   <= disp_in;
            pix_x_q     <= 4'(h_addr % 10'd9);
            pix_y_q     <= v_addr[3:0];
            cursor_on_q <= disp_in && cursor_hit && blink_q;
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            blink_q     <= ~blink_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    // ---------------- cursor arithmetic ----------------
    logic [ROW_W-1:0] adv_row, back_row, nl_row;
    logic [COL_W-1:0] adv_col, back_col;
    logic [11:0]      cur_addr, back_addr;

    always_comb begin
        nl_row = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
        if (col_q == LAST_COL) begin
            adv_col = '0;
            adv_row = nl_row;
        end else begin
            adv_col = col_q + 1'b1;
            adv_row = row_q;
        end
        if (col_q == '0) begin
            back_col = LAST_COL;
            back_row = row_q - 1'b1;
        end else begin
            back_col = col_q - 1'b1;
            back_row = row_q;
        end
    end

    assign cur_addr  = 12'(row_q) * 12'(COLS) + 12'(col_q);
    assign back_addr = 12'(back_row) * 12'(COLS) + 12'(back_col);

    // ---------------- editor FSM ----------------
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_adv_d  = wr_adv_q;
        clr_ptr_d = clr_ptr_q;
        key_ready = (state_q == IDLE);
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        mem_addr  = valid ? disp_addr : ((state_q == CLEAR) ? clr_ptr_q : wr_addr_q);

        unique case (state_q)
            IDLE: begin
                if (key_valid) begin
                    if (key_ascii >= 8'h20 && key_ascii <= 8'h7E) begin
                        wr_addr_d = cur_addr;
                        wr_data_d = key_ascii;
                        wr_adv_d  = 1'b1;
                        state_d   = WRITE;
                    end else if (key_ascii == 8'h08) begin
                        if (row_q != '0 || col_q != '0) begin
                            row_d     = back_row;
                            col_d     = back_col;
                            wr_addr_d = back_addr;
                            wr_data_d = 8'h20;
                            wr_adv_d  = 1'b0;
                            state_d   = WRITE;
                        end
                    end else if (key_ascii == 8'h0D) begin
                        col_d = '0;
                        row_d = nl_row;
                    end else if (key_ascii == 8'h1B) begin
                        clr_ptr_d = '0;
                        state_d   = CLEAR;
                    end
                end
            end
            WRITE: begin
                if (!valid) begin
                    mem_we    = 1'b1;
                    mem_wdata = wr_data_q;
                    if (wr_adv_q) begin
                        row_d = adv_row;
                        col_d = adv_col;
                    end
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                if (!valid) begin
                    mem_we    = 1'b1;
                    mem_wdata = 8'h20;
                    if (clr_ptr_q == LAST_CELL) begin
                        clr_ptr_d = '0;
                        row_d     = '0;
                        col_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        clr_ptr_d = clr_ptr_q + 12'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
            wr_adv_q  <= 1'b0;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_adv_q  <= wr_adv_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

endmodule

// File: tb/tb_text_edit_ctrl.sv
// Directed bench for text_edit_ctrl: behavioural character RAM, write monitor,
// and hand-computed expectations for display mapping, editing, clear and blink.
module tb_text_edit_ctrl;

    logic        pclk, reset;
    logic        key_valid;
    logic [7:0]  key_ascii;
    logic        key_ready;
    logic [9:0]  h_addr, v_addr;
    logic        valid;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  char_code;
    logic [3:0]  pix_x, pix_y;
    logic        cursor_on;

    text_edit_ctrl #(.COLS(70), .ROWS(30), .BLINK_CYCLES(8)) dut (
        .pclk      (pclk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_ascii (key_ascii),
        .key_ready (key_ready),
        .h_addr    (h_addr),
        .v_addr    (v_addr),
        .valid     (valid),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .char_code (char_code),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .cursor_on (cursor_on)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic [7:0] ram [4096];
    always @(posedge pclk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt = 0, wr_in_valid = 0, clr_err = 0, clr_exp = 0;
    logic [11:0] last_addr;
    logic [7:0]  last_data;
    logic        clr_mode = 1'b0;

    always @(negedge pclk) begin
        if (!reset && mem_we) begin
            wr_cnt++;
            last_addr = mem_addr;
            last_data = mem_wdata;
            if (valid) wr_in_valid++;
            if (clr_mode) begin
                if (mem_addr != 12'(clr_exp) || mem_wdata != 8'h20) clr_err++;
                clr_exp++;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic send_key(input logic [7:0] c);
        key_ascii = c;
        key_valid = 1'b1;
        @(posedge pclk);
        #1 key_valid = 1'b0;
    endtask

    task automatic key_write(input string tag, input logic [7:0] c,
                             input logic [11:0] exp_addr, input logic [7:0] exp_data);
        int n0;
        n0 = wr_cnt;
        send_key(c);
        step(2);
        check_eq({tag, "_cnt"}, wr_cnt - n0, 1);
        check_eq({tag, "_addr"}, last_addr, exp_addr);
        check_eq({tag, "_data"}, last_data, exp_data);
    endtask

    task automatic key_nowrite(input string tag, input logic [7:0] c);
        int n0;
        n0 = wr_cnt;
        send_key(c);
        step(3);
        check_eq({tag, "_cnt"}, wr_cnt - n0, 0);
        check_eq({tag, "_rdy"}, key_ready, 1);
    endtask

    task automatic type_quiet(input logic [7:0] c);
        send_key(c);
        step(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, ones;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[72] = 8'h5A;
        ram[70] = 8'h33;
        reset = 1'b1; key_valid = 1'b0; key_ascii = 8'h00;
        h_addr = 10'd0; v_addr = 10'd0; valid = 1'b0;
        step(3);
        check_eq("rst_we", mem_we, 0);
        check_eq("rst_wdata", mem_wdata, 8'h00);
        check_eq("rst_char", char_code, 8'h00);
        check_eq("rst_pix", {pix_x, pix_y}, 8'h00);
        check_eq("rst_cursor", cursor_on, 0);
        reset = 1'b0;
        @(negedge pclk);
        check_eq("rst_ready", key_ready, 1);

        // display mapping
        step(1);
        h_addr = 10'd18; v_addr = 10'd16; valid = 1'b1;
        @(negedge pclk);
        check_eq("disp_addr72", mem_addr, 12'd72);
        check_eq("disp_we0", mem_we, 0);
        @(negedge pclk);
        check_eq("disp_char72", char_code, 8'h5A);
        check_eq("disp_pix72", {pix_x, pix_y}, 8'h00);
        step(1);
        h_addr = 10'd20; v_addr = 10'd35;
        @(negedge pclk);
        check_eq("disp_addr142", mem_addr, 12'd142);
        @(negedge pclk);
        check_eq("disp_pix_x2", pix_x, 4'd2);
        check_eq("disp_pix_y3", pix_y, 4'd3);
        step(1);
        h_addr = 10'd635; v_addr = 10'd0;
        step(1);
        @(negedge pclk);
        check_eq("disp_right_char", char_code, 8'h00);
        h_addr = 10'd18; v_addr = 10'd16; valid = 1'b0;
        step(1);
        @(negedge pclk);
        check_eq("disp_blank_char", char_code, 8'h00);
        step(1);

        // key during active video stalls, then writes on blanking
        valid = 1'b1;
        n0 = wr_cnt;
        send_key(8'h41);
        check_eq("stall_ready0", key_ready, 0);
        step(5);
        check_eq("stall_nowrite", wr_cnt - n0, 0);
        valid = 1'b0;
        step(2);
        check_eq("stall_cnt", wr_cnt - n0, 1);
        check_eq("stall_addr", last_addr, 12'd0);
        check_eq("stall_data", last_data, 8'h41);
        check_eq("stall_in_valid", wr_in_valid, 0);

        for (int i = 0; i < 68; i++) type_quiet(8'h78);
        step(1);
        check_eq("row0_last_addr", last_addr, 12'd68);
        key_write("eol_wrap", 8'h42, 12'd69, 8'h42);
        key_write("row1_col0", 8'h43, 12'd70, 8'h43);

        key_write("bs_mid", 8'h08, 12'd70, 8'h20);
        key_write("bs_rowback", 8'h08, 12'd69, 8'h20);
        key_write("after_bs", 8'h44, 12'd69, 8'h44);

        key_nowrite("cr", 8'h0D);
        key_write("after_cr", 8'h45, 12'd140, 8'h45);

        for (int i = 0; i < 27; i++) type_quiet(8'h0D);
        for (int i = 0; i < 69; i++) type_quiet(8'h79);
        step(1);
        check_eq("row29_last_addr", last_addr, 12'd2098);
        key_write("last_cell", 8'h42, 12'd2099, 8'h42);
        key_write("wrap_home", 8'h46, 12'd0, 8'h46);

        key_write("bs_to_home", 8'h08, 12'd0, 8'h20);
        key_nowrite("bs_at_home", 8'h08);
        key_nowrite("ignored_bel", 8'h07);
        key_write("home_char", 8'h47, 12'd0, 8'h47);

        // full clear, paused first by active video
        valid = 1'b1;
        clr_mode = 1'b1; clr_exp = 0; clr_err = 0;
        n0 = wr_cnt;
        send_key(8'h1B);
        step(10);
        check_eq("clr_paused", wr_cnt - n0, 0);
        valid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step(1);
            if (key_ready) break;
        end
        clr_mode = 1'b0;
        check_eq("clr_done_ready", key_ready, 1);
        check_eq("clr_count", wr_cnt - n0, 2100);
        check_eq("clr_seq_err", clr_err, 0);
        check_eq("clr_ram_2099", ram[2099], 8'h20);
        key_write("clr_home", 8'h48, 12'd0, 8'h48);

        // reset in the middle of a clear
        send_key(8'h1B);
        step(50);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_we", mem_we, 0);
        n0 = wr_cnt;
        step(2);
        reset = 1'b0;
        @(negedge pclk);
        check_eq("mid_rst_ready", key_ready, 1);
        step(5);
        check_eq("mid_rst_nowrite", wr_cnt - n0, 0);
        key_write("mid_rst_home", 8'h49, 12'd0, 8'h49);

        // cursor blink at (0,1): half-period 8 -> 16 of every 32 cycles
        valid = 1'b1; h_addr = 10'd10; v_addr = 10'd3;
        step(3);
        ones = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge pclk);
            if (cursor_on) ones++;
        end
        check_eq("blink_on_cell", ones, 16);
        step(1);
        h_addr = 10'd0;
        step(3);
        ones = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge pclk);
            if (cursor_on) ones++;
        end
        check_eq("blink_off_cell", ones, 0);
        valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/text_edit_ctrl.md
TEXT_EDIT_CTRL -- requirements
Module: text_edit_ctrl

Interface
REQ-001 Parameter COLS, default 70: character columns per row; cells are 9 pixels wide.
REQ-002 Parameter ROWS, default 30: character rows; cells are 16 pixels tall.
REQ-003 Parameter BLINK_CYCLES, default 12500000: pclk cycles per cursor blink half-period.
REQ-004 pclk  in  1  pixel clock; all logic SHALL be rising-edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 key_valid  in  1  keyboard ASCII code available.
REQ-007 key_ascii  in  8  ASCII code.
REQ-008 key_ready  out  1  block accepts a code this cycle.
REQ-009 h_addr  in  10  active pixel x, 0..639.
REQ-010 v_addr  in  10  active pixel y, 0..479.
REQ-011 valid  in  1  display active region.
REQ-012 mem_addr  out  12  character RAM address, row*COLS+col.
REQ-013 mem_we  out  1  character RAM write strobe.
REQ-014 mem_wdata  out  8  character RAM write data.
REQ-015 mem_rdata  in  8  character RAM read data, 1-cycle synchronous read.
REQ-016 char_code  out  8  character for the current pixel, to the font ROM.
REQ-017 pix_x  out  4  pixel column inside the cell, 0..8.
REQ-018 pix_y  out  4  pixel row inside the cell, 0..15.
REQ-019 cursor_on  out  1  current pixel lies in the visible cursor cell.

Function
REQ-020 Display priority: while valid=1, mem_addr SHALL equal (v_addr/16)*COLS + h_addr/9, and mem_we SHALL be 0.
REQ-021 char_code, pix_x, pix_y and cursor_on SHALL be registered, with 1-cycle latency from h_addr/v_addr.
REQ-022 For h_addr >= 9*COLS (630..639), or when valid=0, char_code SHALL be 0x00 and cursor_on SHALL be 0.
REQ-023 Editor writes SHALL occur only in cycles where valid=0; a pending write SHALL stall while valid=1.
REQ-024 FSM states: IDLE, WRITE, CLEAR.
REQ-025 key_ready SHALL be 1 only in IDLE.
REQ-026 A key is accepted on key_valid & key_ready; the command executes as follows.
REQ-027 Code 0x20..0x7E: go to WRITE; write the code at the cursor on the first blanking cycle; advance the cursor; return to IDLE.
REQ-028 Cursor advance: col+1. At col COLS-1, go to col 0 and row+1. At (ROWS-1, COLS-1), wrap to (0,0).
REQ-029 Code 0x08 (backspace) at (0,0): no-op; stay in IDLE.
REQ-030 Code 0x08 elsewhere: move the cursor back one cell (col 0 goes to col COLS-1 of row-1), then go to WRITE and write 0x20 at the new position.
REQ-031 Code 0x0D: col=0; row+1, wrapping ROWS-1 to 0; no RAM write; stay in IDLE.
REQ-032 Code 0x1B: go to CLEAR; write 0x20 to addresses 0..ROWS*COLS-1 in ascending order, one per blanking cycle, pausing while valid=1; then cursor=(0,0) and return to IDLE.
REQ-033 All other codes: accepted and ignored.
REQ-034 Blink counter: counts pclk cycles 0..BLINK_CYCLES-1; blink phase toggles at wrap.
REQ-035 cursor_on SHALL be 1 only when the displayed cell equals the cursor cell and blink phase=1.
REQ-036 Address arithmetic: 12 bits wide; ROWS*COLS SHALL be at most 4096.

Reset
REQ-037 On reset: FSM=IDLE, cursor=(0,0), blink counter=0, blink phase=0, clear pointer=0.
REQ-038 On reset: mem_we=0, mem_wdata=0x00, char_code=0x00, pix_x=0, pix_y=0, cursor_on=0.
REQ-039 key_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-040 Reset during WRITE or CLEAR SHALL abort the operation with no further writes; RAM contents are not restored.

Verification
REQ-041 Key 0x41 while valid=1 for 5 cycles -> mem_we stays 0 for those cycles; then one pulse at addr 0 with data 0x41; cursor becomes (0,1).
REQ-042 Cursor at (0,69), key 0x42 -> write at addr 69; cursor (1,0). Cursor at (29,69) -> write at addr 2099; cursor (0,0).
REQ-043 Backspace at (1,0) -> cursor (0,69); 0x20 written at addr 69. Backspace at (0,0) -> no write; key_ready stays 1.
REQ-044 ESC with valid=0 throughout -> exactly 2100 write pulses, addresses 0..2099 with data 0x20; then key_ready=1 and cursor (0,0).
REQ-045 h_addr=18, v_addr=16, valid=1 -> mem_addr=72; next cycle char_code=mem_rdata, pix_x=0, pix_y=0.
REQ-046 Reset asserted mid-CLEAR -> mem_we=0 immediately; key_ready=1 after reset release.
